// File: rtl/cache_pkg.sv
// Shared definitions for the cache fill controller: FSM state codes, default widths and the
// address that is always treated as a lookup miss.
package cache_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StLookup = 3'd1;
  localparam state_t StMemRd  = 3'd2;
  localparam state_t StMemWr  = 3'd3;
  localparam state_t StFill   = 3'd4;
  localparam state_t StDone   = 3'd5;

  // Power-up cache entries are zero, so a hit on address 0 cannot be trusted.
  localparam logic [63:0] FORCED_MISS_ADDR = 64'd0;

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Bundles the CPU, lookup-cache and memory signals of the fill controller.
// master = controller view, slave = environment (CPU, cache, memory) view.
interface cache_fill_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              REQ;
  logic              REQ_WR;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [DATA_W-1:0] REQ_WDATA;
  logic              READY;
  logic              VALID;
  logic [DATA_W-1:0] RDATA;
  logic              ERR;
  logic [ADDR_W-1:0] LK_ADDR;
  logic [DATA_W-1:0] LK_DIN;
  logic              LK_WE;
  logic [DATA_W-1:0] LK_DOUT;
  logic              LK_FOUND;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic              MEM_RE;
  logic              MEM_WE;
  logic              MEM_RDY;
  logic [DATA_W-1:0] MEM_RDATA;
  logic [31:0]       HIT_CNT;
  logic [31:0]       MISS_CNT;

  modport master (
    input  REQ, REQ_WR, REQ_ADDR, REQ_WDATA, LK_DOUT, LK_FOUND, MEM_RDY, MEM_RDATA,
    output READY, VALID, RDATA, ERR, LK_ADDR, LK_DIN, LK_WE, MEM_ADDR, MEM_WDATA,
    output MEM_RE, MEM_WE, HIT_CNT, MISS_CNT
  );

  modport slave (
    output REQ, REQ_WR, REQ_ADDR, REQ_WDATA, LK_DOUT, LK_FOUND, MEM_RDY, MEM_RDATA,
    input  READY, VALID, RDATA, ERR, LK_ADDR, LK_DIN, LK_WE, MEM_ADDR, MEM_WDATA,
    input  MEM_RE, MEM_WE, HIT_CNT, MISS_CNT
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Request-side fill controller for the shift-in lookup cache.
// Define CACHE_STATS_EN to build the read hit/miss counters; otherwise they read as zero.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input logic               CLK,
  input logic               RST,
  cache_fill_ctrl_if.master bus
);

  localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_fill;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [TMO_W-1:0]  r_tmo;
  logic              w_hit;
  logic              w_tmo_done;

  assign w_hit      = bus.LK_FOUND && (r_addr != ADDR_W'(FORCED_MISS_ADDR));
  assign w_tmo_done = (r_tmo == TMO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:   if (bus.REQ) w_state_nxt = StLookup;
      StLookup: begin
        if (r_wr)       w_state_nxt = StMemWr;
        else if (w_hit) w_state_nxt = StDone;
        else            w_state_nxt = StMemRd;
      end
      StMemRd, StMemWr: begin
        if (bus.MEM_RDY)     w_state_nxt = StFill;
        else if (w_tmo_done) w_state_nxt = StDone;
      end
      StFill:   w_state_nxt = StDone;
      StDone:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StIdle;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_fill  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        StIdle: begin
          if (bus.REQ) begin
            r_wr    <= bus.REQ_WR;
            r_addr  <= bus.REQ_ADDR;
            r_wdata <= bus.REQ_WDATA;
            r_err   <= 1'b0;
          end
        end
        StLookup: begin
          r_tmo <= '0;
          if (!r_wr && w_hit) r_rdata <= bus.LK_DOUT;
        end
        StMemRd, StMemWr: begin
          if (bus.MEM_RDY) begin
            r_fill <= r_wr ? r_wdata : bus.MEM_RDATA;
          end else if (w_tmo_done) begin
            r_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        StFill: begin
          if (!r_wr) r_rdata <= r_fill;
        end
        default: ;
      endcase
    end
  end

  assign bus.READY     = (r_state == StIdle);
  assign bus.VALID     = (r_state == StDone);
  assign bus.ERR       = (r_state == StDone) && r_err;
  assign bus.RDATA     = r_rdata;
  assign bus.LK_ADDR   = r_addr;
  assign bus.LK_DIN    = r_fill;
  assign bus.LK_WE     = (r_state == StFill);
  assign bus.MEM_ADDR  = r_addr;
  assign bus.MEM_WDATA = r_wdata;
  assign bus.MEM_RE    = (r_state == StMemRd);
  assign bus.MEM_WE    = (r_state == StMemWr);

`ifdef CACHE_STATS_EN
  logic        w_hit_inc;
  logic        w_miss_inc;
  logic [31:0] w_hit_cnt;
  logic [31:0] w_miss_cnt;

  assign w_hit_inc  = (r_state == StLookup) && !r_wr && w_hit;
  assign w_miss_inc = (r_state == StLookup) && !r_wr && !w_hit;

  sat_counter #(.WIDTH(32)) u_hit_cnt (
    .i_clk (CLK),
    .i_clr (RST),
    .i_inc (w_hit_inc),
    .o_cnt (w_hit_cnt)
  );

  sat_counter #(.WIDTH(32)) u_miss_cnt (
    .i_clk (CLK),
    .i_clr (RST),
    .i_inc (w_miss_inc),
    .o_cnt (w_miss_cnt)
  );

  assign bus.HIT_CNT  = w_hit_cnt;
  assign bus.MISS_CNT = w_miss_cnt;
`else
  assign bus.HIT_CNT  = '0;
  assign bus.MISS_CNT = '0;
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomized bench for cache_fill_ctrl with a transaction-level reference model
// (latency, result data, error and fill events per request).
module tb_cache_fill_ctrl;

  localparam int unsigned Tmo = 8;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [31:0] m_rdata;
  int          m_hits;
  int          m_misses;

  cache_fill_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  cache_fill_ctrl #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MEM_TIMEOUT (Tmo)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters();
`ifdef CACHE_STATS_EN
    check_eq("hit_cnt", 64'(bus.HIT_CNT), 64'(m_hits));
    check_eq("miss_cnt", 64'(bus.MISS_CNT), 64'(m_misses));
`else
    check_eq("hit_cnt", 64'(bus.HIT_CNT), 64'd0);
    check_eq("miss_cnt", 64'(bus.MISS_CNT), 64'd0);
`endif
  endtask

  // k = cycle of the memory state in which MEM_RDY is returned; 0 or k > Tmo means never.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit found, input logic [31:0] dout, input int k);
    bit          hit;
    int          exp_lat;
    bit          exp_err;
    int          exp_fills;
    int          exp_strobes;
    logic [31:0] mem_val;
    logic [31:0] fill_val;
    int          c;
    int          m;
    int          fills;
    int          strobes;
    bit          seen;

    hit     = !wr && found && (addr != 32'd0);
    mem_val = $urandom;
    if (hit) begin
      exp_lat = 2; exp_err = 1'b0; exp_fills = 0; exp_strobes = 0;
      m_rdata = dout;
    end else if (k >= 1 && k <= int'(Tmo)) begin
      exp_lat = 3 + k; exp_err = 1'b0; exp_fills = 1; exp_strobes = k;
    end else begin
      exp_lat = 2 + int'(Tmo); exp_err = 1'b1; exp_fills = 0; exp_strobes = int'(Tmo);
    end
    fill_val = wr ? wdata : mem_val;
    if (!hit && !exp_err && !wr) m_rdata = mem_val;
    if (!wr) begin
      if (hit) m_hits++;
      else     m_misses++;
    end

    check_eq("ready_idle", 64'(bus.READY), 64'd1);
    bus.REQ       = 1'b1;
    bus.REQ_WR    = wr;
    bus.REQ_ADDR  = addr;
    bus.REQ_WDATA = wdata;
    bus.LK_FOUND  = found;
    bus.LK_DOUT   = dout;
    step();

    c = 1; m = 0; fills = 0; strobes = 0; seen = 1'b0;
    while (c <= 40 && !seen) begin
      // Junk requests while busy must be ignored.
      bus.REQ       = 1'($urandom_range(0, 1));
      bus.REQ_WR    = 1'($urandom_range(0, 1));
      bus.REQ_ADDR  = $urandom;
      bus.REQ_WDATA = $urandom;
      bus.MEM_RDY   = 1'b0;
      bus.MEM_RDATA = $urandom;
      if (bus.READY) check_eq("ready_busy", 64'(bus.READY), 64'd0);
      if (bus.MEM_RE || bus.MEM_WE) begin
        m++;
        strobes++;
        check_eq("mem_dir", {bus.MEM_RE, bus.MEM_WE}, wr ? 64'd1 : 64'd2);
        check_eq("mem_addr", 64'(bus.MEM_ADDR), 64'(addr));
        if (wr) check_eq("mem_wdata", 64'(bus.MEM_WDATA), 64'(wdata));
        if (m == k) begin
          bus.MEM_RDY   = 1'b1;
          bus.MEM_RDATA = mem_val;
        end
      end
      if (bus.LK_WE) begin
        fills++;
        check_eq("lk_addr", 64'(bus.LK_ADDR), 64'(addr));
        check_eq("lk_din", 64'(bus.LK_DIN), 64'(fill_val));
      end
      if (bus.VALID) begin
        seen = 1'b1;
        check_eq("latency", 64'(c), 64'(exp_lat));
        check_eq("err", 64'(bus.ERR), 64'(exp_err));
        check_eq("rdata", 64'(bus.RDATA), 64'(m_rdata));
      end else begin
        step();
        c++;
      end
    end
    if (!seen) check_eq("valid_seen", 64'd0, 64'd1);
    check_eq("fill_count", 64'(fills), 64'(exp_fills));
    check_eq("strobe_count", 64'(strobes), 64'(exp_strobes));
    bus.REQ     = 1'b0;
    bus.MEM_RDY = 1'b0;
    step();
    check_eq("ready_after", 64'(bus.READY), 64'd1);
    check_eq("valid_pulse", 64'(bus.VALID), 64'd0);
    check_counters();
  endtask

  task automatic run_reset_mid_wait();
    int m;
    int bad;
    bus.REQ      = 1'b1;
    bus.REQ_WR   = 1'b0;
    bus.REQ_ADDR = 32'h440;
    bus.LK_FOUND = 1'b0;
    step();
    bus.REQ = 1'b0;
    m = 0;
    for (int c = 0; c < 20 && m < 2; c++) begin
      if (bus.MEM_RE) m++;
      if (m < 2) step();
    end
    check_eq("rst_reach_memrd2", 64'(m), 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_mem_re", 64'(bus.MEM_RE), 64'd0);
    check_eq("rst_ready", 64'(bus.READY), 64'd1);
    check_eq("rst_valid", 64'(bus.VALID), 64'd0);
    check_eq("rst_lk_we", 64'(bus.LK_WE), 64'd0);
    check_eq("rst_rdata", 64'(bus.RDATA), 64'd0);
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.VALID || bus.LK_WE || bus.MEM_RE) bad++;
    end
    check_eq("rst_quiet", 64'(bad), 64'd0);
    m_rdata = 32'd0; m_hits = 0; m_misses = 0;
    check_counters();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_rdata = 32'd0; m_hits = 0; m_misses = 0;
    rst = 1'b1;
    bus.REQ = 1'b0; bus.REQ_WR = 1'b0; bus.REQ_ADDR = '0; bus.REQ_WDATA = '0;
    bus.LK_DOUT = '0; bus.LK_FOUND = 1'b0; bus.MEM_RDY = 1'b0; bus.MEM_RDATA = '0;
    step();
    step();
    check_eq("reset_ready", 64'(bus.READY), 64'd1);
    check_eq("reset_valid", 64'(bus.VALID), 64'd0);
    check_eq("reset_err", 64'(bus.ERR), 64'd0);
    check_eq("reset_rdata", 64'(bus.RDATA), 64'd0);
    check_eq("reset_strobes", {bus.LK_WE, bus.MEM_RE, bus.MEM_WE}, 64'd0);
    check_eq("reset_lk_addr", 64'(bus.LK_ADDR), 64'd0);
    check_eq("reset_mem_addr", 64'(bus.MEM_ADDR), 64'd0);
    check_counters();
    rst = 1'b0;
    step();

    run_txn(1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF, 1);
    run_txn(1'b0, 32'h200, 32'h0, 1'b0, 32'h0, 3);
    run_txn(1'b1, 32'h300, 32'hA5A5A5A5, 1'b1, 32'h5555AAAA, 4);
    run_txn(1'b0, 32'h0, 32'h0, 1'b1, 32'hCAFEF00D, 2);
    run_txn(1'b0, 32'h500, 32'h0, 1'b0, 32'h0, 0);
    run_txn(1'b1, 32'h504, 32'h11112222, 1'b0, 32'h0, 0);
    run_txn(1'b0, 32'h508, 32'h0, 1'b0, 32'h0, int'(Tmo));
    run_reset_mid_wait();

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom & 32'h0000FFFC);
      run_txn(($urandom_range(0, 3) == 0), a, $urandom, 1'($urandom_range(0, 1)),
              $urandom, int'($urandom_range(1, Tmo + 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
